boid_frame_writer: RTL and testbench
====================================

Name: boid_frame_writer

Overview:
Per-frame sequencer that renders all active boids into the boid display framebuffer.
- On each screen-end pulse it requests a framebuffer swap/clear, then walks boids 0..num_active-1.
- For each boid it reads the X/Y position and writes a SPRITE_SIZE×SPRITE_SIZE square of '1' pixels, clipped at the screen edges.
- It sits between the BPU array (position mux via boid_sel) and the resettable pixel RAM, replacing the ad-hoc single-pixel loop in the top level.

Parameters:
- NUM_BOIDS, 8, maximum boids supported; boid_sel width is IDX_W = $clog2(NUM_BOIDS).
- SPRITE_SIZE, 2, side of the square drawn per boid in pixels (1..8).
- SCREEN_W, 640, visible width.
- SCREEN_H, 480, visible height.
- X_WIDTH, 10, boid x coordinate width.
- Y_WIDTH, 9, boid y coordinate width.
- ADDR_WIDTH, 19, framebuffer address width (must satisfy 2^ADDR_WIDTH >= SCREEN_W*SCREEN_H).

Ports:
- clock  in  1  system clock (50 MHz domain); all state changes on posedge.
- reset  in  1  asynchronous, active-high; all state and outputs clear immediately.
- frame_end  in  1  single-cycle pulse from the VGA controller at end of the visible frame.
- num_active  in  IDX_W+1  runtime boid count; sampled when frame_end is accepted; values above NUM_BOIDS are clamped to NUM_BOIDS.
- overrun_clr  in  1  clears the overrun flag.
- boid_sel  out  IDX_W  index of the boid whose position is requested; drives the position mux.
- boid_x  in  X_WIDTH  x of the selected boid; valid in the cycle after boid_sel settles.
- boid_y  in  Y_WIDTH  y of the selected boid; same timing as boid_x.
- fb_swap  out  1  one-cycle pulse that switches the framebuffer to a cleared bank.
- fb_we  out  1  framebuffer write enable.
- fb_addr  out  ADDR_WIDTH  write address, equal to y*SCREEN_W + x.
- fb_wdata  out  1  constant 1 while fb_we is high, 0 otherwise.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the frame has been fully drawn.
- overrun  out  1  sticky flag: a frame_end arrived while busy.
- frame_count  out  16  number of completed frames; wraps at 0xFFFF -> 0.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; boid index, dx and dy counters at 0.
- FSM states: IDLE, SWAP, FETCH, DRAW, DONE.
- IDLE: on frame_end, latch the clamped num_active and go to SWAP. Otherwise stay in IDLE.
- SWAP (1 cycle):
  - fb_swap=1, boid_sel=0.
  - Next state is FETCH if num_active>0, else DONE.
- FETCH (1 cycle): boid_sel=idx; latch boid_x/boid_y into bx/by at the end of the cycle; clear dx and dy; go to DRAW.
- DRAW (exactly SPRITE_SIZE² cycles):
  - Pixel for the cycle is px=bx+dx, py=by+dy, computed at widths X_WIDTH+1 and Y_WIDTH+1 so there is no wrap.
  - fb_we=1 only if px<SCREEN_W and py<SCREEN_H; fb_addr=py*SCREEN_W+px, truncated to ADDR_WIDTH.
  - Out-of-bounds pixels still consume their cycle, so per-boid latency is constant.
  - dx increments each cycle; when dx wraps, dy increments.
  - After the last pixel: idx++. Go to DONE if idx==num_active, else FETCH.
- DONE (1 cycle): done=1, frame_count++, go to IDLE.
- Latency: frame_end accepted at cycle 0 gives done at cycle 2 + num_active*(1+SPRITE_SIZE²).
- fb_addr is don't-care when fb_we=0; the bench checks it only when fb_we=1.
- fb_swap is asserted only in SWAP.
- No write occurs in the same cycle as fb_swap.
- frame_end while busy:
  - The pulse is ignored; the current frame continues unchanged.
  - overrun is set the next cycle.
  - If overrun_clr arrives in the same cycle as a new overrun event, set wins.
- frame_end in the DONE cycle counts as busy: overrun is set and no restart occurs.
- The coordinate multiply is constant; implement as shift-add (for 640: (y<<9)+(y<<7)). No DSP inference is required.
- Reset mid-frame:
  - fb_we and fb_swap drop to 0 immediately; no partial done pulse is emitted.
  - frame_count and overrun clear.

Decomposition:
- Package boid_pkg holds:
  - SCREEN_W, SCREEN_H, PIXEL_COUNT, ADDR_WIDTH, MAX_BOIDS.
  - The writer state enum (IDLE/SWAP/FETCH/DRAW/DONE) with a 3-bit encoding.
- One sub-module, boid_pixel_addr: combinational; takes (px, py) and returns {in_bounds, addr}. It is reused by the VGA read path.

Test Plan:
1. NUM_BOIDS=8, SPRITE_SIZE=2, num_active=1, boid0 at (10,10), frame_end at cycle 0 -> fb_swap at cycle 1; fb_we at cycles 3–6 with addrs 6410, 6411, 7050, 7051; done at cycle 7; frame_count=1.
2. num_active=8, all boids in-bounds -> exactly 32 writes; done at cycle 42; busy high for cycles 1–42.
3. Boid at (639,479), SPRITE_SIZE=2 -> a single write at addr 307199; the DRAW phase still lasts 4 cycles.
4. num_active=0 -> fb_swap at cycle 1, done at cycle 2, no fb_we.
5. num_active=12 -> clamped to 8 (done at cycle 42). A second frame_end at cycle 20 -> overrun=1, no restart. overrun_clr pulse -> overrun=0.
6. reset asserted mid-DRAW of boid 3 -> fb_we=0 immediately, busy=0, frame_count=0. The next frame_end produces a full, correct 8-boid frame.

Source files
------------

// File: rtl/boid_pkg.sv
// -----------------------------------------------------------------------------
// boid_pkg
// Shared screen geometry and framebuffer constants for the boid display path,
// plus the frame-writer state encoding.
// -----------------------------------------------------------------------------
package boid_pkg;

    localparam int SCREEN_W    = 640;
    localparam int SCREEN_H    = 480;
    localparam int PIXEL_COUNT = SCREEN_W * SCREEN_H;
    localparam int ADDR_WIDTH  = 19;
    localparam int MAX_BOIDS   = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SWAP  = 3'd1,
        ST_FETCH = 3'd2,
        ST_DRAW  = 3'd3,
        ST_DONE  = 3'd4
    } wr_state_e;

endpackage

// File: rtl/boid_pixel_addr.sv
// -----------------------------------------------------------------------------
// boid_pixel_addr
// Combinational pixel-to-framebuffer address mapping, shared by the frame
// writer and the VGA read path.
//   px_i        in  X_WIDTH+1   pixel x (one extra bit so sprite overhang
//                               past the right edge does not wrap)
//   py_i        in  Y_WIDTH+1   pixel y (same extra bit)
//   in_bounds_o out 1           pixel lies inside the visible screen
//   addr_o      out ADDR_WIDTH  py*SCREEN_W + px, truncated
// -----------------------------------------------------------------------------
module boid_pixel_addr
    import boid_pkg::*;
#(
    parameter int SCREEN_W   = boid_pkg::SCREEN_W,
    parameter int SCREEN_H   = boid_pkg::SCREEN_H,
    parameter int X_WIDTH    = 10,
    parameter int Y_WIDTH    = 9,
    parameter int ADDR_WIDTH = boid_pkg::ADDR_WIDTH
) (
    input  logic [X_WIDTH:0]      px_i,
    input  logic [Y_WIDTH:0]      py_i,
    output logic                  in_bounds_o,
    output logic [ADDR_WIDTH-1:0] addr_o
);

    localparam logic [X_WIDTH:0] W_LIM  = (X_WIDTH+1)'(SCREEN_W);
    localparam logic [Y_WIDTH:0] H_LIM  = (Y_WIDTH+1)'(SCREEN_H);
    localparam logic [31:0]      W_BITS = 32'(SCREEN_W);

    logic [ADDR_WIDTH-1:0] row;

    // Constant multiply by SCREEN_W as a sum of shifted copies of y, one per
    // set bit of the width (640 -> (y<<9)+(y<<7)); keeps it out of DSPs.
    always_comb begin
        row = '0;
        for (int k = 0; k < 32; k++) begin
            if (W_BITS[k]) row = row + (ADDR_WIDTH'(py_i) << k);
        end
    end

    assign in_bounds_o = (px_i < W_LIM) && (py_i < H_LIM);
    assign addr_o      = row + ADDR_WIDTH'(px_i);

endmodule

// File: rtl/boid_frame_writer.sv
// -----------------------------------------------------------------------------
// boid_frame_writer
// Per-frame sequencer: on each frame_end it requests a cleared framebuffer
// bank, then walks boids 0..num_active-1 and draws a SPRITE_SIZE^2 square of
// '1' pixels at each boid position, clipped at the screen edges.
//   clock, reset     system clock, async active-high reset
//   frame_end        end-of-visible-frame pulse from the VGA controller
//   num_active       runtime boid count (clamped to NUM_BOIDS), sampled on start
//   overrun_clr      clears the sticky overrun flag
//   boid_sel         index for the BPU position mux
//   boid_x, boid_y   position of the selected boid (one cycle after boid_sel)
//   fb_swap          one-cycle bank swap/clear request
//   fb_we/addr/wdata framebuffer write port
//   busy, done       activity flag and end-of-frame pulse
//   overrun          frame_end arrived while busy
//   frame_count      completed frames, wrapping 16-bit
// All outputs are registered; the pixel for each DRAW cycle is computed one
// cycle ahead (from boid_x/y in FETCH, from the next dx/dy in DRAW).
// -----------------------------------------------------------------------------
module boid_frame_writer
    import boid_pkg::*;
#(
    parameter int NUM_BOIDS   = boid_pkg::MAX_BOIDS,
    parameter int SPRITE_SIZE = 2,
    parameter int SCREEN_W    = boid_pkg::SCREEN_W,
    parameter int SCREEN_H    = boid_pkg::SCREEN_H,
    parameter int X_WIDTH     = 10,
    parameter int Y_WIDTH     = 9,
    parameter int ADDR_WIDTH  = boid_pkg::ADDR_WIDTH,
    localparam int IDX_W      = $clog2(NUM_BOIDS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  frame_end,
    input  logic [IDX_W:0]        num_active,
    input  logic                  overrun_clr,
    output logic [IDX_W-1:0]      boid_sel,
    input  logic [X_WIDTH-1:0]    boid_x,
    input  logic [Y_WIDTH-1:0]    boid_y,
    output logic                  fb_swap,
    output logic                  fb_we,
    output logic [ADDR_WIDTH-1:0] fb_addr,
    output logic                  fb_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun,
    output logic [15:0]           frame_count
);

    localparam int             DW     = (SPRITE_SIZE > 1) ? $clog2(SPRITE_SIZE) : 1;
    localparam logic [DW-1:0]  LAST_D = DW'(SPRITE_SIZE - 1);
    localparam logic [IDX_W:0] MAXN   = (IDX_W+1)'(NUM_BOIDS);

    wr_state_e             state_q;
    logic [IDX_W:0]        idx_q, n_q;
    logic [X_WIDTH-1:0]    bx_q;
    logic [Y_WIDTH-1:0]    by_q;
    logic [DW-1:0]         dx_q, dy_q;
    logic [IDX_W-1:0]      boid_sel_q;
    logic                  fb_swap_q, fb_we_q, busy_q, done_q, overrun_q;
    logic [ADDR_WIDTH-1:0] fb_addr_q;
    logic [15:0]           frame_count_q;

    logic [DW-1:0]         dx_d, dy_d;
    logic                  last_pix;
    logic [IDX_W:0]        idx_inc, n_clamp;
    logic [X_WIDTH:0]      px_d;
    logic [Y_WIDTH:0]      py_d;
    logic                  pix_in;
    logic [ADDR_WIDTH-1:0] pix_addr;

    always_comb begin
        last_pix = (dx_q == LAST_D) && (dy_q == LAST_D);
        dx_d     = (dx_q == LAST_D) ? '0 : dx_q + 1'b1;
        dy_d     = (dx_q == LAST_D) ? dy_q + 1'b1 : dy_q;
        idx_inc  = idx_q + 1'b1;
        n_clamp  = (num_active > MAXN) ? MAXN : num_active;
        // Pixel to be written in the next cycle
        if (state_q == ST_FETCH) begin
            px_d = {1'b0, boid_x};
            py_d = {1'b0, boid_y};
        end else begin
            px_d = {1'b0, bx_q} + (X_WIDTH+1)'(dx_d);
            py_d = {1'b0, by_q} + (Y_WIDTH+1)'(dy_d);
        end
    end

    boid_pixel_addr #(
        .SCREEN_W   (SCREEN_W),
        .SCREEN_H   (SCREEN_H),
        .X_WIDTH    (X_WIDTH),
        .Y_WIDTH    (Y_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_pix (
        .px_i        (px_d),
        .py_i        (py_d),
        .in_bounds_o (pix_in),
        .addr_o      (pix_addr)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            n_q           <= '0;
            bx_q          <= '0;
            by_q          <= '0;
            dx_q          <= '0;
            dy_q          <= '0;
            boid_sel_q    <= '0;
            fb_swap_q     <= 1'b0;
            fb_we_q       <= 1'b0;
            fb_addr_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            overrun_q     <= 1'b0;
            frame_count_q <= '0;
        end else begin
            fb_swap_q <= 1'b0;
            fb_we_q   <= 1'b0;
            fb_addr_q <= '0;
            done_q    <= 1'b0;

            // Set takes priority over clear
            if (frame_end && state_q != ST_IDLE) overrun_q <= 1'b1;
            else if (overrun_clr)                overrun_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (frame_end) begin
                        n_q        <= n_clamp;
                        idx_q      <= '0;
                        boid_sel_q <= '0;
                        fb_swap_q  <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= ST_SWAP;
                    end
                end
                ST_SWAP: begin
                    if (n_q != '0) begin
                        state_q <= ST_FETCH;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_FETCH: begin
                    bx_q      <= boid_x;
                    by_q      <= boid_y;
                    dx_q      <= '0;
                    dy_q      <= '0;
                    fb_we_q   <= pix_in;
                    fb_addr_q <= pix_addr;
                    state_q   <= ST_DRAW;
                end
                ST_DRAW: begin
                    if (last_pix) begin
                        idx_q <= idx_inc;
                        if (idx_inc == n_q) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            boid_sel_q <= idx_inc[IDX_W-1:0];
                            state_q    <= ST_FETCH;
                        end
                    end else begin
                        dx_q      <= dx_d;
                        dy_q      <= dy_d;
                        fb_we_q   <= pix_in;
                        fb_addr_q <= pix_addr;
                    end
                end
                ST_DONE: begin
                    frame_count_q <= frame_count_q + 1'b1;
                    boid_sel_q    <= '0;
                    busy_q        <= 1'b0;
                    state_q       <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign boid_sel    = boid_sel_q;
    assign fb_swap     = fb_swap_q;
    assign fb_we       = fb_we_q;
    assign fb_addr     = fb_addr_q;
    assign fb_wdata    = fb_we_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign overrun     = overrun_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_boid_frame_writer.sv
// -----------------------------------------------------------------------------
// tb_boid_frame_writer
// Scoreboard bench: a frame model pushes the expected writes (cycle, address)
// for every frame it starts; each cycle the DUT outputs are compared against
// the head of the queue and the expected swap/done/busy timing.
// -----------------------------------------------------------------------------
module tb_boid_frame_writer;

    localparam int SPR = 2;

    typedef struct {
        int cyc;
        int addr;
    } wr_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        frame_end;
    logic [3:0]  num_active;
    logic        overrun_clr;
    logic [2:0]  boid_sel;
    logic [9:0]  boid_x;
    logic [8:0]  boid_y;
    logic        fb_swap, fb_we, fb_wdata, busy, done, overrun;
    logic [18:0] fb_addr;
    logic [15:0] frame_count;

    logic [9:0]  pos_x [8];
    logic [8:0]  pos_y [8];

    wr_t exp_q[$];
    int  n_chk  = 0;
    int  n_fail = 0;
    int  fc_exp = 0;
    int  wr_seen;

    always #5 clock = ~clock;

    // Position mux stand-in for the BPU array
    assign boid_x = pos_x[boid_sel];
    assign boid_y = pos_y[boid_sel];

    boid_frame_writer #(
        .NUM_BOIDS   (8),
        .SPRITE_SIZE (SPR)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .frame_end   (frame_end),
        .num_active  (num_active),
        .overrun_clr (overrun_clr),
        .boid_sel    (boid_sel),
        .boid_x      (boid_x),
        .boid_y      (boid_y),
        .fb_swap     (fb_swap),
        .fb_we       (fb_we),
        .fb_addr     (fb_addr),
        .fb_wdata    (fb_wdata),
        .busy        (busy),
        .done        (done),
        .overrun     (overrun),
        .frame_count (frame_count)
    );

    task automatic chk(input string tag, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Starts a frame with frame_end at relative cycle 0 and checks every cycle
    // up to the one after done. fe_at: cycle of an extra frame_end (-1 none).
    // rst_at: cycle at which reset is asserted mid-frame (-1 none).
    task automatic run_frame(input int n_req, input int fe_at, input int rst_at);
        int  n, t, done_at, px, py;
        bit  exp_we;
        wr_t e;
        n = (n_req > 8) ? 8 : n_req;
        exp_q.delete();
        t = 3;
        for (int b = 0; b < n; b++) begin
            for (int dy = 0; dy < SPR; dy++) begin
                for (int dx = 0; dx < SPR; dx++) begin
                    px = int'(pos_x[b]) + dx;
                    py = int'(pos_y[b]) + dy;
                    if (px < 640 && py < 480) begin
                        e.cyc  = t;
                        e.addr = py * 640 + px;
                        exp_q.push_back(e);
                    end
                    t++;
                end
            end
            t++;
        end
        done_at = 2 + n * (1 + SPR * SPR);
        wr_seen = 0;

        @(negedge clock);
        num_active = 4'(n_req);
        frame_end  = 1'b1;
        for (int rel = 1; rel <= done_at + 1; rel++) begin
            @(negedge clock);
            frame_end = 1'b0;
            if (rel == rst_at) begin
                reset = 1'b1;
                #1;
                chk("rst_we", fb_we, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_swap", fb_swap, 0);
                chk("rst_frame_count", frame_count, 0);
                fc_exp = 0;
                exp_q.delete();
                @(negedge clock);
                reset = 1'b0;
                return;
            end
            chk("swap", fb_swap, rel == 1);
            chk("done", done, rel == done_at);
            chk("busy", busy, rel <= done_at);
            exp_we = (exp_q.size() > 0) && (exp_q[0].cyc == rel);
            chk("we", fb_we, exp_we);
            if (fb_we) wr_seen++;
            if (exp_we) begin
                e = exp_q.pop_front();
                if (fb_we) begin
                    chk("addr", fb_addr, e.addr);
                    chk("wdata", fb_wdata, 1);
                end
            end
            if (fe_at > 0 && rel == fe_at + 1) chk("overrun_set", overrun, 1);
            if (rel == done_at + 1) begin
                fc_exp = (fc_exp + 1) & 16'hFFFF;
                chk("frame_count", frame_count, fc_exp);
            end
            frame_end = (rel == fe_at);
        end
        chk("writes_left", exp_q.size(), 0);
    endtask

    initial begin
        reset       = 1'b1;
        frame_end   = 1'b0;
        num_active  = '0;
        overrun_clr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            pos_x[i] = 10'(20 + 70 * i);
            pos_y[i] = 9'(15 + 50 * i);
        end
        repeat (3) @(negedge clock);
        chk("reset_busy", busy, 0);
        chk("reset_we", fb_we, 0);
        chk("reset_swap", fb_swap, 0);
        chk("reset_done", done, 0);
        chk("reset_overrun", overrun, 0);
        chk("reset_frame_count", frame_count, 0);
        chk("reset_sel", boid_sel, 0);
        reset = 1'b0;
        @(negedge clock);

        // Single boid at (10,10): writes 6410, 6411, 7050, 7051
        pos_x[0] = 10'd10;
        pos_y[0] = 9'd10;
        run_frame(1, -1, -1);
        chk("t1_writes", wr_seen, 4);

        // Eight in-bounds boids at random positions
        for (int i = 0; i < 8; i++) begin
            pos_x[i] = 10'($urandom_range(0, 630));
            pos_y[i] = 9'($urandom_range(0, 470));
        end
        run_frame(8, -1, -1);
        chk("t2_writes", wr_seen, 32);

        // Bottom-right corner: only one pixel survives clipping
        pos_x[0] = 10'd639;
        pos_y[0] = 9'd479;
        run_frame(1, -1, -1);
        chk("t3_writes", wr_seen, 1);

        // Right/bottom edge straddle for a second boid
        pos_x[1] = 10'd639;
        pos_y[1] = 9'd100;
        pos_x[0] = 10'd300;
        pos_y[0] = 9'd479;
        run_frame(2, -1, -1);
        chk("edge_writes", wr_seen, 4);

        // No boids
        run_frame(0, -1, -1);
        chk("t4_writes", wr_seen, 0);

        // Clamp 12 -> 8, extra frame_end while busy sets overrun without restart
        for (int i = 0; i < 8; i++) begin
            pos_x[i] = 10'(5 + 75 * i);
            pos_y[i] = 9'(400 - 45 * i);
        end
        run_frame(12, 20, -1);
        chk("t5_writes", wr_seen, 32);
        @(negedge clock);
        chk("no_restart", busy, 0);
        chk("overrun_sticky", overrun, 1);
        overrun_clr = 1'b1;
        @(negedge clock);
        overrun_clr = 1'b0;
        chk("overrun_cleared", overrun, 0);

        // Reset during DRAW of boid 3, then a clean full frame
        run_frame(8, -1, 19);
        @(negedge clock);
        chk("post_rst_busy", busy, 0);
        run_frame(8, -1, -1);
        chk("t6_writes", wr_seen, 32);

        repeat (2) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
